// File: rtl/mem_pkg.sv
// Shared types for the SSRAM controller: default widths, FSM states, grant encoding.
package mem_pkg;

    localparam int W_DEF = 8;
    localparam int N_DEF = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR     = 3'd1,
        RD     = 3'd2,
        RD_CAP = 3'd3,
        ACK    = 3'd4
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_rr_arb.sv
// Round-robin grant between the fetch and data ports.
// Latency: combinational grant; pointer updates on the clock after a contested grant.
// Backpressure: none; the losing request simply stays pending.
module mem_rr_arb
    import mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic dm_req,
    input  logic upd,
    output gnt_t gnt
);

    gnt_t last_q;

    // The pointer only tracks contested grants, so an uncontested grant
    // does not steal the next turn from the other port.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= GNT_IF;
        end else if (upd && if_req && dm_req) begin
            last_q <= gnt;
        end
    end

    always_comb begin
        gnt = GNT_DM;
        if (if_req && dm_req) begin
            gnt = (last_q == GNT_DM) ? GNT_IF : GNT_DM;
        end else if (if_req) begin
            gnt = GNT_IF;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Two-port (fetch + data) controller for a single-cycle synchronous SRAM.
// Latency: store ack 2 cycles, load/fetch ack 3 cycles after the request is taken in IDLE.
// Backpressure: requests are held by the requester until its one-cycle ack.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         if_req,
    input  logic [N-1:0] if_addr,
    output logic         if_ack,
    output logic [W-1:0] if_rdata,
    input  logic         dm_req,
    input  logic         dm_we,
    input  logic [N-1:0] dm_addr,
    input  logic [W-1:0] dm_wdata,
    output logic         dm_ack,
    output logic [W-1:0] dm_rdata,
    output logic         mem_cs,
    output logic         mem_we,
    output logic         mem_oe,
    output logic [N-1:0] mem_addr,
    output logic [W-1:0] mem_di,
    input  logic [W-1:0] mem_do
);

    state_t       state_q, state_d;
    gnt_t         gnt, gnt_q;
    logic         we_q;
    logic [N-1:0] addr_q;
    logic [W-1:0] wdata_q;
    logic [W-1:0] if_rdata_q, dm_rdata_q;
    logic         take;

    assign take = (state_q == IDLE) && (if_req || dm_req);

    mem_rr_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .if_req (if_req),
        .dm_req (dm_req),
        .upd    (take),
        .gnt    (gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= GNT_DM;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                gnt_q <= gnt;
                if (gnt == GNT_DM) begin
                    we_q    <= dm_we;
                    addr_q  <= dm_addr;
                    wdata_q <= dm_wdata;
                end else begin
                    we_q    <= 1'b0;
                    addr_q  <= if_addr;
                    wdata_q <= '0;
                end
            end
            if (state_q == RD_CAP) begin
                if (gnt_q == GNT_IF) begin
                    if_rdata_q <= mem_do;
                end else begin
                    dm_rdata_q <= mem_do;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mem_cs   = 1'b0;
        mem_we   = 1'b0;
        mem_oe   = 1'b0;
        mem_addr = '0;
        mem_di   = '0;
        if_ack   = 1'b0;
        dm_ack   = 1'b0;
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = (gnt == GNT_DM && dm_we) ? WR : RD;
                end
            end
            WR: begin
                mem_cs   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = addr_q;
                mem_di   = wdata_q;
                state_d  = ACK;
            end
            RD: begin
                mem_cs   = 1'b1;
                mem_oe   = 1'b1;
                mem_addr = addr_q;
                state_d  = RD_CAP;
            end
            RD_CAP: begin
                mem_cs   = 1'b1;
                mem_oe   = 1'b1;
                mem_addr = addr_q;
                state_d  = ACK;
            end
            ACK: begin
                if_ack  = (gnt_q == GNT_IF);
                dm_ack  = (gnt_q == GNT_DM);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed and randomized checks of mem_ctrl against an SSRAM model and a reference memory.
module tb_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       if_req = 1'b0;
    logic [7:0] if_addr = '0;
    logic       if_ack;
    logic [7:0] if_rdata;
    logic       dm_req = 1'b0;
    logic       dm_we = 1'b0;
    logic [7:0] dm_addr = '0;
    logic [7:0] dm_wdata = '0;
    logic       dm_ack;
    logic [7:0] dm_rdata;
    logic       mem_cs, mem_we, mem_oe;
    logic [7:0] mem_addr, mem_di;
    logic [7:0] mem_do;

    int checks = 0;
    int failures = 0;

    logic [7:0] ssram   [256];
    logic [7:0] ref_mem [256];
    logic [7:0] exp_if = '0;
    logic [7:0] exp_dm = '0;

    mem_ctrl #(.W(8), .N(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_ack   (dm_ack),
        .dm_rdata (dm_rdata),
        .mem_cs   (mem_cs),
        .mem_we   (mem_we),
        .mem_oe   (mem_oe),
        .mem_addr (mem_addr),
        .mem_di   (mem_di),
        .mem_do   (mem_do)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        return 8'((i * 37 + 91) ^ (i >> 3));
    endfunction

    // Synchronous SRAM: write on cs&we, read data valid one clock after cs&oe.
    initial begin
        for (int i = 0; i < 256; i++) ssram[i] = init_val(i);
        mem_do <= '0;
        forever begin
            @(posedge clk);
            if (mem_cs && mem_we) ssram[mem_addr] = mem_di;
            if (mem_cs && mem_oe) mem_do <= ssram[mem_addr];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cs"},   32'(mem_cs),   0);
        check({tag, "_we"},   32'(mem_we),   0);
        check({tag, "_oe"},   32'(mem_oe),   0);
        check({tag, "_addr"}, 32'(mem_addr), 0);
        check({tag, "_di"},   32'(mem_di),   0);
        check({tag, "_acks"}, 32'({if_ack, dm_ack}), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_req = 1'b0;
        dm_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset_if_rdata", 32'(if_rdata), 0);
        check("reset_dm_rdata", 32'(dm_rdata), 0);
        rst = 1'b0;
        exp_if = '0;
        exp_dm = '0;
    endtask

    // Waits (bounded) for either ack, checking we/oe exclusivity every cycle.
    task automatic wait_ack(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            check("we_oe_exclusive", 32'(mem_we & mem_oe), 0);
        end while (!(if_ack || dm_ack) && cnt < 10);
    endtask

    task automatic do_txn(input bit on_dm, input bit we, input logic [7:0] a, input logic [7:0] d);
        int cnt;
        if (on_dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = d;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        cnt = 0;
        @(negedge clk);
        cnt++;
        check("txn_cs",   32'(mem_cs),   1);
        check("txn_addr", 32'(mem_addr), 32'(a));
        check("txn_we",   32'(mem_we),   32'(we));
        if (we) check("txn_di", 32'(mem_di), 32'(d));
        while (!(if_ack || dm_ack) && cnt < 10) begin
            @(negedge clk);
            cnt++;
            check("we_oe_exclusive", 32'(mem_we & mem_oe), 0);
        end
        check("txn_ack_port", 32'({if_ack, dm_ack}), on_dm ? 32'd1 : 32'd2);
        check("txn_latency", 32'(cnt), we ? 32'd2 : 32'd3);
        if (we) ref_mem[a] = d;
        else if (on_dm) exp_dm = ref_mem[a];
        else exp_if = ref_mem[a];
        check("txn_dm_rdata", 32'(dm_rdata), 32'(exp_dm));
        check("txn_if_rdata", 32'(if_rdata), 32'(exp_if));
        dm_req = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        int kind;
        logic [7:0] a, d;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

        do_reset();

        // Directed store 0xA5 -> 0x12
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h12; dm_wdata = 8'hA5;
        @(negedge clk);
        check("st_cs",   32'(mem_cs),   1);
        check("st_we",   32'(mem_we),   1);
        check("st_oe",   32'(mem_oe),   0);
        check("st_addr", 32'(mem_addr), 32'h12);
        check("st_di",   32'(mem_di),   32'hA5);
        check("st_early_ack", 32'(dm_ack), 0);
        @(negedge clk);
        check("st_ack", 32'(dm_ack), 1);
        check("st_ack_cs", 32'(mem_cs), 0);
        check("st_ack_di", 32'(mem_di), 0);
        dm_req = 1'b0;
        ref_mem[8'h12] = 8'hA5;
        @(negedge clk);
        check("st_no_reack", 32'(dm_ack), 0);

        // Directed load from 0x12
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h12;
        @(negedge clk);
        check("ld_oe1",   32'(mem_oe),   1);
        check("ld_we",    32'(mem_we),   0);
        check("ld_addr",  32'(mem_addr), 32'h12);
        @(negedge clk);
        check("ld_oe2",   32'(mem_oe),   1);
        check("ld_early_ack", 32'(dm_ack), 0);
        @(negedge clk);
        check("ld_ack",    32'(dm_ack),   1);
        check("ld_oe_off", 32'(mem_oe),   0);
        check("ld_rdata",  32'(dm_rdata), 32'hA5);
        check("ld_if_unchanged", 32'(if_rdata), 0);
        dm_req = 1'b0;
        exp_dm = 8'hA5;
        @(negedge clk);

        // Round-robin: simultaneous after reset -> dm first, next pair -> if first
        do_reset();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h12; if_req = 1'b1; if_addr = 8'h40;
        wait_ack(cnt);
        check("rr1_first", 32'({if_ack, dm_ack}), 1);
        check("rr1_lat", 32'(cnt), 3);
        check("rr1_dm_rdata", 32'(dm_rdata), 32'(ref_mem[8'h12]));
        dm_req = 1'b0;
        wait_ack(cnt);
        check("rr1_second", 32'({if_ack, dm_ack}), 2);
        check("rr1_if_rdata", 32'(if_rdata), 32'(ref_mem[8'h40]));
        if_req = 1'b0;
        @(negedge clk);
        dm_req = 1'b1; dm_addr = 8'h41; if_req = 1'b1; if_addr = 8'h42;
        wait_ack(cnt);
        check("rr2_first", 32'({if_ack, dm_ack}), 2);
        check("rr2_if_rdata", 32'(if_rdata), 32'(ref_mem[8'h42]));
        if_req = 1'b0;
        wait_ack(cnt);
        check("rr2_second", 32'({if_ack, dm_ack}), 1);
        check("rr2_dm_rdata", 32'(dm_rdata), 32'(ref_mem[8'h41]));
        dm_req = 1'b0;
        exp_if = ref_mem[8'h42];
        exp_dm = ref_mem[8'h41];
        @(negedge clk);

        // Reset during RD_CAP aborts the load with no ack
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h12;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_rdcap_oe", 32'(mem_oe), 1);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("abort");
        check("abort_dm_rdata", 32'(dm_rdata), 0);
        check("abort_if_rdata", 32'(if_rdata), 0);
        rst = 1'b0;
        dm_req = 1'b0;
        exp_if = '0;
        exp_dm = '0;
        @(negedge clk);
        check("abort_no_late_ack", 32'({if_ack, dm_ack}), 0);
        do_txn(1'b1, 1'b0, 8'h12, 8'h00);

        // Random mix of stores, loads and fetches over the full range
        for (int n = 0; n < 1000; n++) begin
            kind = int'($urandom_range(0, 2));
            a = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            case (kind)
                0:       do_txn(1'b1, 1'b1, a, d);
                1:       do_txn(1'b1, 1'b0, a, d);
                default: do_txn(1'b0, 1'b0, a, d);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter W, default 8, data width in bits.
REQ-002 Parameter N, default 8, address width in bits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 if_req  input  1  instruction-fetch read request, held until if_ack.
REQ-006 if_addr  input  N  fetch address, stable while if_req high.
REQ-007 if_ack  output  1  one-cycle pulse; fetch complete, if_rdata valid.
REQ-008 if_rdata  output  W  fetch data, held until the next fetch completes.
REQ-009 dm_req  input  1  data-port request, held until dm_ack.
REQ-010 dm_we  input  1  1 = store, 0 = load; stable while dm_req high.
REQ-011 dm_addr  input  N  data address, stable while dm_req high.
REQ-012 dm_wdata  input  W  store data, stable while dm_req high.
REQ-013 dm_ack  output  1  one-cycle pulse; load/store complete.
REQ-014 dm_rdata  output  W  load data, held until the next load completes.
REQ-015 mem_cs, mem_we, mem_oe  output  1 each  SSRAM chip select, write enable, output enable.
REQ-016 mem_addr  output  N  SSRAM address.
REQ-017 mem_di  output  W  SSRAM write data (to d_i).
REQ-018 mem_do  input  W  SSRAM read data (from d_o); valid one clock after an oe cycle.

Function
REQ-019 The FSM SHALL have states IDLE, WR, RD, RD_CAP and ACK.
REQ-020 In IDLE with any request pending, the block SHALL latch the granted port, address, data and we, then go to WR (store) or RD (load/fetch).
REQ-021 Arbitration SHALL be round-robin: with both requests pending, the port not granted last wins; after reset, dm wins first.
REQ-022 WR SHALL last 1 cycle with mem_cs=1, mem_we=1, mem_oe=0, latched mem_addr and mem_di, then go to ACK.
REQ-023 RD SHALL last 1 cycle with mem_cs=1, mem_oe=1, mem_we=0, latched mem_addr, then go to RD_CAP.
REQ-024 RD_CAP SHALL hold mem_cs=1, mem_oe=1, sample mem_do into the granted port's rdata register at the cycle end, then go to ACK.
REQ-025 ACK SHALL assert exactly one of if_ack/dm_ack for 1 cycle, ignore all requests, then go to IDLE.
REQ-026 Latency from request sampled in IDLE to ack: 2 cycles for store, 3 cycles for load/fetch; throughput 1 store per 3 cycles, 1 read per 4 cycles.
REQ-027 Outside WR/RD/RD_CAP, mem_cs, mem_we and mem_oe SHALL be 0, and mem_di SHALL be 0 outside WR.
REQ-028 A read SHALL update only the granted port's rdata; the other port's rdata is unchanged.
REQ-029 A request dropped before its ack is a protocol violation; the in-flight transaction SHALL still complete and ack.
REQ-030 Addresses SHALL pass through unmodified (full 2**N range, no wrap logic).

Reset
REQ-031 While rst is high at a clock edge: state goes to IDLE; all mem_* outputs, if_ack, dm_ack, if_rdata, dm_rdata are 0; the round-robin pointer selects dm.
REQ-032 Reset mid-transaction SHALL abort it with no ack; the requester re-issues.

Structure
REQ-033 Package mem_pkg SHALL hold the W/N defaults, the state enum (IDLE, WR, RD, RD_CAP, ACK) and the grant enum (GNT_IF, GNT_DM).
REQ-034 The round-robin grant SHALL be a sub-module mem_rr_arb (inputs: two requests, an update strobe; output: grant).

Verification
REQ-035 Store dm_addr=0x12, dm_wdata=0xA5 -> mem_cs=mem_we=1, mem_addr=0x12, mem_di=0xA5 for 1 cycle; dm_ack 2 cycles after the request is sampled.
REQ-036 Load dm_addr=0x12 after REQ-035 -> mem_oe=1 for 2 cycles; dm_rdata=0xA5 with dm_ack 3 cycles after the request; if_rdata unchanged.
REQ-037 if_req and dm_req raised in the same cycle after reset -> dm served first, then if; on the next simultaneous pair, if first.
REQ-038 rst asserted during RD_CAP -> no ack; all outputs 0 next cycle; a re-issued request completes normally.
REQ-039 Random test of 1000 stores/loads over the full address and data range against a reference memory -> zero mismatches; mem_we and mem_oe never both 1.
